// File: rtl/fp_result_packer.sv
// fp_result_packer: normalizes, rounds (nearest-even) and packs an FP add/sub result into IEEE-754 single precision.
// Build option: define FP_PACK_SUBNORMAL_EN to keep tiny results as subnormals instead of flushing to signed zero.
module fp_result_packer #(
    parameter int WIDTH = 32,
    parameter int EXP_W = 8,
    parameter int MAN_W = 23
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             sign_in,
    input  logic [EXP_W:0]   exp_in,
    input  logic [MAN_W+4:0] man_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             overflow,
    output logic             underflow,
    output logic             inexact
);
    localparam int MW = MAN_W + 5;
    localparam int SW = MAN_W + 1;
    localparam logic [EXP_W:0] EXP_MAX = {1'b0, {EXP_W{1'b1}}};
    localparam logic [EXP_W:0] EXP_ONE = {{EXP_W{1'b0}}, 1'b1};

    typedef enum logic [1:0] {IDLE, NORM, ROUND, DONE} state_t;
    state_t state, state_next;

    logic             sign_r;
    logic [EXP_W:0]   exp_r;
    logic [MW-1:0]    man_r;
    logic             zero_r;
    logic             ovf_r;
    logic             tiny_r;

    logic take;
    logic release_out;
    logic norm_zero;
    logic norm_ovf;
    logic norm_carry;
    logic norm_hidden;
    logic norm_shift;

    assign in_ready    = (state == IDLE) && !rst;
    assign take        = in_valid && in_ready;
    assign release_out = out_valid && out_ready;

    // Normalization decision, in priority order: zero, overflow, carry, already normalized, shift, tiny.
    assign norm_zero   = (man_r == '0);
    assign norm_ovf    = (exp_r >= EXP_MAX);
    assign norm_carry  = man_r[MW-1];
    assign norm_hidden = man_r[MW-2];
    assign norm_shift  = !norm_zero && !norm_ovf && !norm_carry && !norm_hidden && (exp_r > EXP_ONE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:  if (take) state_next = NORM;
            NORM:  if (!norm_shift) state_next = ROUND;
            ROUND: state_next = DONE;
            DONE:  if (release_out) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    logic             guard;
    logic             rnd;
    logic             sticky;
    logic             round_up;
    logic [SW:0]      sum;
    logic [EXP_W:0]   exp_rnd;
    logic [MAN_W-1:0] frac_rnd;
    logic [WIDTH-1:0] pack_result;
    logic             pack_ovf;
    logic             pack_unf;
    logic             pack_inx;

    // Rounding: a carry out of the 24-bit significand leaves 1.000.. so the fraction is the upper bits.
    always_comb begin
        guard    = man_r[2];
        rnd      = man_r[1];
        sticky   = man_r[0];
        round_up = guard & (rnd | sticky | man_r[3]);
        sum      = {1'b0, man_r[MW-2:3]} + {{SW{1'b0}}, round_up};
        exp_rnd  = exp_r;
        frac_rnd = sum[MAN_W-1:0];
        if (sum[SW]) begin
            frac_rnd = sum[MAN_W:1];
            exp_rnd  = exp_r + EXP_ONE;
        end

        pack_result = '0;
        pack_ovf    = 1'b0;
        pack_unf    = 1'b0;
        pack_inx    = guard | rnd | sticky;
        if (zero_r) begin
            pack_inx = 1'b0;
        end else if (ovf_r || (exp_rnd >= EXP_MAX)) begin
            pack_result = {sign_r, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
            pack_ovf    = 1'b1;
            pack_inx    = 1'b1;
        end else if (tiny_r) begin
`ifdef FP_PACK_SUBNORMAL_EN
            // A round-up into the hidden position naturally becomes exponent field 1.
            pack_result = {sign_r, {(EXP_W-1){1'b0}}, sum[MAN_W], sum[MAN_W-1:0]};
            pack_unf    = pack_inx;
`else
            pack_result = {sign_r, {(WIDTH-1){1'b0}}};
            pack_unf    = 1'b1;
            pack_inx    = 1'b1;
`endif
        end else begin
            pack_result = {sign_r, exp_rnd[EXP_W-1:0], frac_rnd};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sign_r    <= 1'b0;
            exp_r     <= '0;
            man_r     <= '0;
            zero_r    <= 1'b0;
            ovf_r     <= 1'b0;
            tiny_r    <= 1'b0;
            result    <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
            inexact   <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (take) begin
                        sign_r <= sign_in;
                        exp_r  <= (exp_in == '0) ? EXP_ONE : exp_in;
                        man_r  <= man_in;
                        zero_r <= 1'b0;
                        ovf_r  <= 1'b0;
                        tiny_r <= 1'b0;
                    end
                end
                NORM: begin
                    if (norm_zero) begin
                        zero_r <= 1'b1;
                    end else if (norm_ovf) begin
                        ovf_r <= 1'b1;
                    end else if (norm_carry) begin
                        man_r <= {1'b0, man_r[MW-1:2], man_r[1] | man_r[0]};
                        exp_r <= exp_r + EXP_ONE;
                    end else if (norm_shift) begin
                        man_r <= {man_r[MW-2:0], 1'b0};
                        exp_r <= exp_r - EXP_ONE;
                    end else if (!norm_hidden) begin
                        tiny_r <= 1'b1;
                    end
                end
                ROUND: begin
                    result    <= pack_result;
                    overflow  <= pack_ovf;
                    underflow <= pack_unf;
                    inexact   <= pack_inx;
                end
                DONE: begin
                    // out_valid rises one cycle into DONE and drops on the accepting edge.
                    if (!out_valid) begin
                        out_valid <= 1'b1;
                    end else if (out_ready) begin
                        out_valid <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: doc/fp_result_packer.md
# fp_result_packer

Back end of the FP add/sub datapath. Takes the result sign, pre-normalization exponent and raw significand from the add/sub stage, then normalizes it with an iterative one-bit shifter. It rounds round-to-nearest-even and packs an IEEE-754 single-precision word. Input and output use valid/ready handshakes, and one operation is in flight at a time.

## Interface
- WIDTH, 32: packed result width.
- EXP_W, 8: exponent field width.
- MAN_W, 23: fraction field width.
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  operand bundle valid.
- in_ready  out  1  high only in IDLE and rst low.
- sign_in  in  1  result sign from the sign logic.
- exp_in  in  EXP_W+1  biased exponent; the extra MSB allows values of 255 and above.
- man_in  in  MAN_W+5  significand: [27] carry, [26] hidden, [25:3] fraction, [2] guard, [1] round, [0] sticky.
- out_valid  out  1  result valid; held until accepted.
- out_ready  in  1  downstream accept.
- result  out  WIDTH  packed {sign, exp, frac}.
- overflow, underflow, inexact  out  1 each  IEEE flags, qualified by out_valid.

## Operation
- States: IDLE, NORM, ROUND, DONE.
- IDLE: on in_valid && in_ready, capture sign, exponent and significand, then go to NORM. An exp_in of 0 is treated as 1.
- NORM performs one action per cycle:
  - man == 0: go to ROUND; the result will be +0 regardless of sign_in.
  - exp ≥ 255: go to ROUND with the overflow condition set.
  - carry bit set: shift right 1, OR the shifted-out bit into sticky, exp+1, go to ROUND.
  - hidden bit 1: go to ROUND.
  - hidden bit 0 and exp > 1: shift left 1, exp−1, stay in NORM.
  - hidden bit 0 and exp == 1: tiny result; go to ROUND with the tiny condition set.
- ROUND:
  - inexact = G|R|S.
  - round_up = G & (R|S|lsb).
  - Add round_up to the 24-bit significand. On carry-out, shift right 1 and exp+1.
  - Pack and register result and flags, then go to DONE.
- Overflow: exp ≥ 255 after rounding gives ±inf 0x7F800000 | sign<<31, with overflow=1 and inexact=1.
- DONE: out_valid=1. On out_ready, go to IDLE. result and flags stay stable while out_ready is low.
- Special operands (NaN, inf input) are resolved upstream and are outside this block's scope.

## Timing
- Reset value of every output:
  - out_valid = 0.
  - result = 0.
  - overflow, underflow, inexact = 0.
  - in_ready = 0 during the rst cycle and 1 in the cycle after.
- rst mid-operation: the capture is discarded, state goes to IDLE, and outputs return to reset values on the next edge.
- Latency, with the handshake on edge T:
  - out_valid rises after edge T+3 + k, where k is the number of left shifts (0..26).
  - Carry, already-normalized, and zero inputs all have k = 0.
- Throughput: the next in_valid is accepted no earlier than the cycle after the DONE handshake. in_ready is 0 in NORM, ROUND and DONE.
- Simultaneous in_valid and rst: rst wins, nothing is captured.

## Configuration
- FP_PACK_SUBNORMAL_EN defined, tiny result:
  - Exponent field 0, fraction taken as-is, then rounded.
  - If rounding sets the hidden bit, the exponent field becomes 1.
  - underflow = tiny & inexact.
- FP_PACK_SUBNORMAL_EN undefined, tiny nonzero result:
  - Flushes to signed zero.
  - underflow = 1 and inexact = 1.

## Test plan
- 1.0+1.0: sign 0, exp 127, man bit27 only -> 0x40000000, flags 0, out_valid 3 cycles after the handshake.
- Cancellation: sign 1, exp 127, man 0 -> 0x00000000 (+0), flags 0.
- Left normalize: exp 127, man bit23 only -> 0x3E000000 after 6 cycles (k=3).
- RNE ties, both with inexact=1:
  - Hidden + bit3 + guard -> 0x3F800002.
  - Hidden + guard only -> 0x3F800000.
- Overflow: exp 254, man bit27 -> 0x7F800000, overflow=1, inexact=1. Same packing with sign 1 -> 0xFF800000.
- Tiny input: exp 1, man bit25 only, out_ready held low 5 cycles then high.
  - With the macro: 0x00400000, underflow=0.
  - Without the macro: 0x00000000, underflow=1.
  - In both builds, result is stable while out_ready is low; rst asserted in NORM gives out_valid=0 on the next edge.
